replay_trace_feeder: RTL and testbench

Synthesizable stimulus sequencer that sits directly upstream of the replay testbench top. It consumes a stream of recorded trace records (poke, expect, step, end), drives the DUT's inputs and clock-enable cycle by cycle, and checks DUT outputs against expected values. When the trace ends it raises `exit`, which the replay top samples to close waveforms and finish.

---
 rtl/replay_trace_feeder_if.sv | 13 +
 rtl/replay_trace_feeder.sv | 147 ++++++++++++++
 tb/tb_replay_trace_feeder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/replay_trace_feeder_if.sv
// Trace record stream between the trace source (master) and replay_trace_feeder (slave).
// A record moves on every clock where rec_valid and rec_ready are both high.
interface replay_trace_feeder_if #(
    parameter int DATA_W = 64
);
    logic              rec_valid;
    logic              rec_ready;
    logic [1:0]        rec_kind;
    logic [DATA_W-1:0] rec_data;

    modport master (output rec_valid, output rec_kind, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_kind, input rec_data, output rec_ready);
endinterface

// File: rtl/replay_trace_feeder.sv
// Replays recorded POKE/EXPECT/STEP/END records into a DUT and scores its outputs.
// Optional idle-fetch watchdog is enabled by defining REPLAY_WATCHDOG_EN.
module replay_trace_feeder #(
    parameter int DATA_W       = 64,
    parameter int STEP_W       = 32,
    parameter int CYCLE_W      = 64,
    parameter int RESET_CYCLES = 5,
    parameter int WATCHDOG     = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    replay_trace_feeder_if.slave  rec,
    output logic                  dut_reset,
    output logic                  dut_en,
    output logic [DATA_W-1:0]     poke_data,
    input  logic [DATA_W-1:0]     peek_data,
    output logic [CYCLE_W-1:0]    cycles,
    output logic [15:0]           mismatches,
    output logic [CYCLE_W-1:0]    first_fail_cycle,
    output logic                  exit,
    output logic                  pass,
    output logic                  timeout
);

    typedef enum logic [1:0] {RST_HOLD, FETCH, STEP, DONE} state_t;
    typedef enum logic [1:0] {K_POKE = 2'd0, K_EXPECT = 2'd1, K_STEP = 2'd2, K_END = 2'd3} kind_t;

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_n;
    kind_t               kind;
    logic                ready;
    logic                hs;
    logic                wd_fire;

    assign kind          = kind_t'(rec.rec_kind);
    assign step_n        = rec.rec_data[STEP_W-1:0];
    assign rec.rec_ready = ready;
    assign hs            = rec.rec_valid & ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        ready     = 1'b0;
        dut_reset = 1'b0;
        dut_en    = 1'b0;
        case (state)
            RST_HOLD: begin
                dut_reset = 1'b1;
                dut_en    = 1'b1;
                if (hold_cnt == HOLD_LAST) state_nxt = FETCH;
            end
            FETCH: begin
                ready = 1'b1;
                if (rec.rec_valid) begin
                    if (kind == K_STEP && step_n != '0) state_nxt = STEP;
                    else if (kind == K_END)             state_nxt = DONE;
                end else if (wd_fire) begin
                    state_nxt = DONE;
                end
            end
            STEP: begin
                dut_en = 1'b1;
                if (step_cnt == STEP_W'(1)) state_nxt = FETCH;
            end
            DONE: ;
            default: state_nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state            <= RST_HOLD;
            hold_cnt         <= '0;
            step_cnt         <= '0;
            poke_data        <= '0;
            cycles           <= '0;
            mismatches       <= '0;
            first_fail_cycle <= '1;
            exit             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == RST_HOLD) hold_cnt <= hold_cnt + 1'b1;
            if (state == STEP) begin
                cycles   <= cycles + 1'b1;
                step_cnt <= step_cnt - 1'b1;
            end
            if (hs) begin
                case (kind)
                    K_POKE:   poke_data <= rec.rec_data;
                    K_EXPECT: begin
                        if (rec.rec_data != peek_data) begin
                            // mismatches only leaves zero on the first failure, so it doubles as the first-fail flag
                            if (mismatches == '0)      first_fail_cycle <= cycles;
                            if (mismatches != 16'hFFFF) mismatches      <= mismatches + 1'b1;
                        end
                    end
                    K_STEP:   step_cnt <= step_n;
                    K_END: begin
                        exit <= 1'b1;
                        pass <= (mismatches == '0) && !timeout;
                    end
                    default: ;
                endcase
            end
            if (wd_fire) begin
                exit <= 1'b1;
                pass <= 1'b0;
            end
        end
    end

`ifdef REPLAY_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    assign wd_fire = (state == FETCH) && !rec.rec_valid && (wd_cnt == WD_W'(WATCHDOG - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == FETCH && !rec.rec_valid) wd_cnt <= wd_cnt + 1'b1;
            else                                  wd_cnt <= '0;
            if (wd_fire) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_watchdog;

    assign unused_watchdog = (WATCHDOG != 0);
    assign wd_fire         = 1'b0;
    assign timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_replay_trace_feeder.sv
// Scoreboard bench for replay_trace_feeder: a trace model pushes expected results as records are driven.
// A second instance with CYCLE_W=8 covers cycle-counter wrap.
module tb_replay_trace_feeder;

    localparam int          RESET_CYCLES = 5;
    localparam logic [1:0]  K_POKE = 2'd0, K_EXPECT = 2'd1, K_STEP = 2'd2, K_END = 2'd3;

    logic        clock;
    logic        reset;
    logic        dut_reset, dut_en, dut_exit, pass, timeout;
    logic [63:0] poke_data, peek_data, cycles, first_fail_cycle;
    logic [15:0] mismatches;

    logic        dut_reset8, dut_en8, dut_exit8, pass8, timeout8;
    logic [63:0] poke_data8, peek_data8;
    logic [7:0]  cycles8, first_fail_cycle8;
    logic [15:0] mismatches8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    logic [63:0] m_poke, m_cycles, m_first;
    logic [15:0] m_mism;

    replay_trace_feeder_if #(.DATA_W(64)) ifc ();
    replay_trace_feeder_if #(.DATA_W(64)) ifc8 ();

    replay_trace_feeder #(
        .DATA_W(64), .STEP_W(32), .CYCLE_W(64), .RESET_CYCLES(RESET_CYCLES), .WATCHDOG(16)
    ) u_dut (
        .clock(clock), .reset(reset), .rec(ifc),
        .dut_reset(dut_reset), .dut_en(dut_en), .poke_data(poke_data), .peek_data(peek_data),
        .cycles(cycles), .mismatches(mismatches), .first_fail_cycle(first_fail_cycle),
        .exit(dut_exit), .pass(pass), .timeout(timeout)
    );

    replay_trace_feeder #(
        .DATA_W(64), .STEP_W(32), .CYCLE_W(8), .RESET_CYCLES(RESET_CYCLES), .WATCHDOG(16)
    ) u_dut8 (
        .clock(clock), .reset(reset), .rec(ifc8),
        .dut_reset(dut_reset8), .dut_en(dut_en8), .poke_data(poke_data8), .peek_data(peek_data8),
        .cycles(cycles8), .mismatches(mismatches8), .first_fail_cycle(first_fail_cycle8),
        .exit(dut_exit8), .pass(pass8), .timeout(timeout8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: simulation still running, required finish");
        $fatal(1, "time limit");
    end

    task automatic hold_reset();
        reset          = 1'b0;
        ifc.rec_valid  = 1'b0;
        ifc8.rec_valid = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic release_reset();
        int hold = 0;
        int k    = 0;
        reset    = 1'b1;
        while (!ifc.rec_ready && k < 50) begin
            if (dut_reset && dut_en) hold++;
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (hold !== RESET_CYCLES || !ifc.rec_ready) begin
            n_bad++;
            $display("FAIL reset_hold: got %0d hold cycles (ready=%b), want %0d", hold, ifc.rec_ready, RESET_CYCLES);
        end
        n_cmp++;
        if (dut_reset !== 1'b0 || cycles !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_release: got dut_reset=%b cycles=%0d, want 0/0", dut_reset, cycles);
        end
        m_poke   = '0;
        m_cycles = '0;
        m_mism   = '0;
        m_first  = '1;
    endtask

    task automatic send_rec(input logic [1:0] kind, input logic [63:0] data);
        int          waited = 0;
        int          en_seen = 0;
        logic [63:0] exp_v;
        case (kind)
            K_POKE: begin
                m_poke = data;
                exp_q.push_back(m_poke);
            end
            K_EXPECT: begin
                if (peek_data !== data) begin
                    if (m_mism == 16'd0)     m_first = m_cycles;
                    if (m_mism != 16'hFFFF) m_mism  = m_mism + 16'd1;
                end
                exp_q.push_back(64'(m_mism));
            end
            K_STEP: begin
                exp_q.push_back(64'(data[31:0]));
                m_cycles = m_cycles + 64'(data[31:0]);
                exp_q.push_back(m_cycles);
            end
            default: exp_q.push_back(64'(m_mism == 16'd0));
        endcase
        ifc.rec_valid = 1'b1;
        ifc.rec_kind  = kind;
        ifc.rec_data  = data;
        while (!ifc.rec_ready && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (!ifc.rec_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake: got rec_ready=0 after %0d cycles, want 1", waited);
            ifc.rec_valid = 1'b0;
            exp_q.delete();
            return;
        end
        @(negedge clock);
        ifc.rec_valid = 1'b0;
        case (kind)
            K_POKE: begin
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (poke_data !== exp_v) begin
                    n_bad++;
                    $display("FAIL poke_data: got %h want %h", poke_data, exp_v);
                end
            end
            K_EXPECT: begin
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (mismatches !== exp_v[15:0]) begin
                    n_bad++;
                    $display("FAIL mismatches: got %0d want %0d", mismatches, exp_v[15:0]);
                end
            end
            K_STEP: begin
                waited = 0;
                while (!ifc.rec_ready && waited < 400) begin
                    if (dut_en) en_seen++;
                    @(negedge clock);
                    waited++;
                end
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (en_seen !== int'(exp_v)) begin
                    n_bad++;
                    $display("FAIL step_en_cycles: got %0d want %0d", en_seen, exp_v);
                end
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (cycles !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycles: got %0d want %0d", cycles, exp_v);
                end
            end
            default: begin
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (dut_exit !== 1'b1 || pass !== exp_v[0]) begin
                    n_bad++;
                    $display("FAIL end_exit_pass: got exit=%b pass=%b want 1/%b", dut_exit, pass, exp_v[0]);
                end
            end
        endcase
    endtask

    task automatic test_reset();
        hold_reset();
        n_cmp++;
        if (ifc.rec_ready !== 1'b0 || dut_reset !== 1'b1 || dut_en !== 1'b1 || dut_exit !== 1'b0 ||
            pass !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ready=%b rst=%b en=%b exit=%b pass=%b to=%b want 0/1/1/0/0/0",
                     ifc.rec_ready, dut_reset, dut_en, dut_exit, pass, timeout);
        end
        n_cmp++;
        if (poke_data !== 64'd0 || cycles !== 64'd0 || mismatches !== 16'd0 || first_fail_cycle !== '1) begin
            n_bad++;
            $display("FAIL reset_values: got poke=%h cyc=%0d mism=%0d ff=%h want 0/0/0/all-ones",
                     poke_data, cycles, mismatches, first_fail_cycle);
        end
        release_reset();
    endtask

    task automatic test_poke_expect_pass();
        hold_reset();
        release_reset();
        send_rec(K_POKE, 64'hA5);
        send_rec(K_STEP, 64'd3);
        peek_data = 64'hA5;
        send_rec(K_EXPECT, 64'hA5);
        send_rec(K_END, 64'd0);
        n_cmp++;
        if (cycles !== 64'd3 || mismatches !== 16'd0) begin
            n_bad++;
            $display("FAIL pass_trace_totals: got cycles=%0d mism=%0d want 3/0", cycles, mismatches);
        end
    endtask

    task automatic test_expect_fail();
        hold_reset();
        release_reset();
        send_rec(K_STEP, 64'd7);
        peek_data = 64'h2;
        send_rec(K_EXPECT, 64'h1);
        peek_data = 64'h4;
        send_rec(K_EXPECT, 64'h3);
        send_rec(K_END, 64'd0);
        n_cmp++;
        if (mismatches !== 16'd2 || first_fail_cycle !== 64'd7 || pass !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_trace_totals: got mism=%0d ff=%0d pass=%b want 2/7/0",
                     mismatches, first_fail_cycle, pass);
        end
    endtask

    task automatic test_corner();
        int k = 0;
        hold_reset();
        release_reset();
        send_rec(K_STEP, 64'd0);
        repeat (3) @(negedge clock);
        send_rec(K_POKE, 64'h5A);
        repeat (2) @(negedge clock);
        // STEP 3 followed by a POKE held valid while the feeder is stepping
        ifc.rec_valid = 1'b1;
        ifc.rec_kind  = K_STEP;
        ifc.rec_data  = 64'd3;
        @(negedge clock);
        ifc.rec_kind  = K_POKE;
        ifc.rec_data  = 64'h3C;
        while (!ifc.rec_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        ifc.rec_valid = 1'b0;
        m_cycles = m_cycles + 64'd3;
        exp_q.push_back(64'h3C);
        exp_q.push_back(m_cycles);
        n_cmp++;
        if (poke_data !== exp_q.pop_front()) begin
            n_bad++;
            $display("FAIL held_poke: got %h want 3c", poke_data);
        end
        n_cmp++;
        if (cycles !== exp_q.pop_front()) begin
            n_bad++;
            $display("FAIL held_step_cycles: got %0d want %0d", cycles, m_cycles);
        end
        // reset in the middle of a long STEP
        ifc.rec_valid = 1'b1;
        ifc.rec_kind  = K_STEP;
        ifc.rec_data  = 64'd50;
        @(negedge clock);
        ifc.rec_valid = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (cycles !== m_cycles + 64'd5) begin
            n_bad++;
            $display("FAIL mid_step_cycles: got %0d want %0d", cycles, m_cycles + 64'd5);
        end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (cycles !== 64'd0 || dut_reset !== 1'b1 || dut_en !== 1'b1 || ifc.rec_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_step_reset: got cyc=%0d rst=%b en=%b ready=%b want 0/1/1/0",
                     cycles, dut_reset, dut_en, ifc.rec_ready);
        end
        release_reset();
    endtask

    task automatic test_watchdog();
        int idle = 0;
        hold_reset();
        release_reset();
`ifdef REPLAY_WATCHDOG_EN
        while (!dut_exit && idle < 100) begin
            @(negedge clock);
            idle++;
        end
        n_cmp++;
        if (idle !== 16 || timeout !== 1'b1 || dut_exit !== 1'b1 || pass !== 1'b0) begin
            n_bad++;
            $display("FAIL watchdog: got idle=%0d to=%b exit=%b pass=%b want 16/1/1/0",
                     idle, timeout, dut_exit, pass);
        end
`else
        repeat (40) @(negedge clock);
        idle = 40;
        n_cmp++;
        if (dut_exit !== 1'b0 || timeout !== 1'b0 || ifc.rec_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL no_watchdog: got exit=%b to=%b ready=%b after %0d idle, want 0/0/1",
                     dut_exit, timeout, ifc.rec_ready, idle);
        end
`endif
    endtask

    task automatic test_wrap();
        int k  = 0;
        int en = 0;
        hold_reset();
        release_reset();
        exp_q.push_back(64'd300);
        exp_q.push_back(64'(300 % 256));
        ifc8.rec_valid = 1'b1;
        ifc8.rec_kind  = K_STEP;
        ifc8.rec_data  = 64'd300;
        while (!ifc8.rec_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        ifc8.rec_valid = 1'b0;
        k = 0;
        while (!ifc8.rec_ready && k < 400) begin
            if (dut_en8) en++;
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (en !== int'(exp_q.pop_front())) begin
            n_bad++;
            $display("FAIL wrap_en_cycles: got %0d want 300", en);
        end
        n_cmp++;
        if (cycles8 !== exp_q.pop_front()) begin
            n_bad++;
            $display("FAIL wrap_cycles: got %0d want 44", cycles8);
        end
    endtask

    task automatic test_saturation();
        hold_reset();
        release_reset();
        peek_data     = 64'd0;
        ifc.rec_valid = 1'b1;
        ifc.rec_kind  = K_EXPECT;
        ifc.rec_data  = 64'd1;
        repeat (65540) @(negedge clock);
        ifc.rec_valid = 1'b0;
        m_first = m_cycles;
        m_mism  = 16'hFFFF;
        exp_q.push_back(64'(m_mism));
        n_cmp++;
        if (mismatches !== exp_q.pop_front()[15:0]) begin
            n_bad++;
            $display("FAIL mism_saturate: got %h want ffff", mismatches);
        end
        n_cmp++;
        if (first_fail_cycle !== m_first) begin
            n_bad++;
            $display("FAIL sat_first_fail: got %0d want %0d", first_fail_cycle, m_first);
        end
        send_rec(K_END, 64'd0);
    endtask

    initial begin
        reset          = 1'b0;
        peek_data      = '0;
        peek_data8     = '0;
        ifc.rec_valid  = 1'b0;
        ifc.rec_kind   = 2'd0;
        ifc.rec_data   = '0;
        ifc8.rec_valid = 1'b0;
        ifc8.rec_kind  = 2'd0;
        ifc8.rec_data  = '0;
        @(negedge clock);
        test_reset();
        test_poke_expect_pass();
        test_expect_fail();
        test_corner();
        test_watchdog();
        test_wrap();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
